// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory bus arbiter: FSM states and fixed indices.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACCESS,
    DATA,
    TURN
  } arb_state_e;

  localparam int VIDEO_IDX     = 0;
  localparam int MIN_CYCLE_LEN = 3;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search over the non-video requesters, starting just after rrLast.
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:1] req,
  input  logic [IW-1:0]   rrLast,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  always_comb begin
    logic [IW-1:0] cand;
    // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Candidates wrap within 1..NREQ-1; index 0 never takes part in the rotation.
    for (int off = 1; off < NREQ; off++) begin
      cand = IW'((int'(rrLast) - 1 + off) % (NREQ - 1) + 1);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Main-memory bus arbiter: video has fixed top priority, the rest share the bus round-robin.
// Each access is ADDR, ACCESS (CYCLE_LEN-2 cycles), DATA, then a TURN bubble unless locked.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int CYCLE_LEN = 4,
  localparam int IW        = $clog2(NREQ),
  localparam int CW        = $clog2(CYCLE_LEN)
) (
  input  logic            MasterClock,
  input  logic            resetL,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   owner,
  output logic            busy,
  output logic            addrLatch,
  output logic            dataLatch,
  output logic [NREQ-1:0] ack
);

  if (CYCLE_LEN < MIN_CYCLE_LEN) begin : gBadCycleLen
    $error("mem_bus_arbiter: CYCLE_LEN must be at least %0d", MIN_CYCLE_LEN);
  end
  if (NREQ < 2 || NREQ > 8) begin : gBadNreq
    $error("mem_bus_arbiter: NREQ must be in 2..8");
  end

  arb_state_e      state, stateNext;
  logic [IW-1:0]   ownerNext, rrLast, rrLastNext;
  logic [CW-1:0]   cnt, cntNext;
  logic            pickValid;
  logic [IW-1:0]   pickIdx;
  logic            inCycle;
  logic [NREQ-1:0] ownerHot;
  logic            keepBus;

  rr_picker #(.NREQ(NREQ)) uPicker (
    .req    (req[NREQ-1:1]),
    .rrLast (rrLast),
    .valid  (pickValid),
    .idx    (pickIdx)
  );

  // A locked owner keeps the bus unless video is waiting and someone else owns it.
  assign keepBus = lock[owner] && req[owner] &&
                   !(req[VIDEO_IDX] && owner != IW'(VIDEO_IDX));

  always_comb begin
    stateNext  = state;
    ownerNext  = owner;
    rrLastNext = rrLast;
    cntNext    = cnt;
    unique case (state)
      IDLE: begin
        if (req[VIDEO_IDX]) begin
          stateNext = ADDR;
          ownerNext = IW'(VIDEO_IDX);
        end else if (pickValid) begin
          stateNext  = ADDR;
          ownerNext  = pickIdx;
          rrLastNext = pickIdx;
        end
      end
      ADDR: begin
        cntNext   = CW'(CYCLE_LEN - MIN_CYCLE_LEN);
        stateNext = ACCESS;
      end
      ACCESS: begin
        if (cnt == '0) stateNext = DATA;
        else           cntNext   = cnt - CW'(1);
      end
      DATA:    stateNext = keepBus ? ADDR : TURN;
      TURN:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    inCycle  = (stateNext == ADDR) || (stateNext == ACCESS) || (stateNext == DATA);
    ownerHot = NREQ'(1) << ownerNext;
  end

  always_ff @(posedge MasterClock or negedge resetL) begin
    if (!resetL) begin
      state     <= IDLE;
      owner     <= '0;
      rrLast    <= IW'(NREQ - 1);
      cnt       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      addrLatch <= 1'b0;
      dataLatch <= 1'b0;
      ack       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= stateNext;
      owner     <= ownerNext;
      rrLast    <= rrLastNext;
      cnt       <= cntNext;
      gnt       <= inCycle ? ownerHot : '0;
      busy      <= inCycle;
      addrLatch <= (stateNext == ADDR);
      dataLatch <= (stateNext == DATA);
      ack       <= (stateNext == DATA) ? ownerHot : '0;
    end
  end

endmodule
